// File: rtl/pipe_muldiv.sv
// ---------------------------------------------------------------------------
// pipe_muldiv -- iterative multiply/divide unit for the EX stage.
//
// Executes MULT / MULTU / DIV / DIVU on the forwarded ID/EX operands with one
// radix-2 iteration per clock, and holds the HI/LO result registers that
// MFHI/MFLO read. While an operation is in flight the front of the pipeline
// is frozen through estall; the owning instruction leaves EX in the DONE
// cycle, when estall drops.
//
// Ports:
//   clock   in   pipeline clock (shared with the EX/MEM register)
//   clr     in   synchronous active-high reset
//   estart  in   EX instruction is a mul/div (sampled only in IDLE)
//   eop     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   ea, eb  in   rs / rt operands after forwarding
//   ehi     out  HI register (product upper half / remainder)
//   elo     out  LO register (product lower half / quotient)
//   ebusy   out  registered, high in RUN and FIX
//   edone   out  registered, one-cycle pulse in DONE
//   edivz   out  registered divide-by-zero flag of the last completed op
//   estall  out  combinational pipeline freeze request
// ---------------------------------------------------------------------------
module pipe_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             estart,
    input  logic [1:0]       eop,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    output logic [WIDTH-1:0] ehi,
    output logic [WIDTH-1:0] elo,
    output logic             ebusy,
    output logic             edone,
    output logic             edivz,
    output logic             estall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_reg;
    logic                 div_reg;      // 1: divide, 0: multiply
    logic [WIDTH-1:0]     b_reg;        // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_reg;      // mul: {hi, lo/multiplier}; div: {rem, quo}
    logic [CW-1:0]        count_reg;
    logic                 neg_lo_reg;   // negate product / quotient
    logic                 neg_hi_reg;   // negate remainder (dividend negative)
    logic [WIDTH-1:0]     ehi_reg;
    logic [WIDTH-1:0]     elo_reg;
    logic                 ebusy_reg;
    logic                 edone_reg;
    logic                 edivz_reg;

    // Operand decode for the start cycle
    logic                 is_signed;
    logic                 is_div;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // Iteration datapath
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       trial;
    logic                 trial_ok;
    logic [2*WIDTH-1:0]   div_next;

    // Sign fix-up
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_comb begin
        is_signed = ~eop[0];
        is_div    = eop[1];
        // -2^(WIDTH-1) negates to itself, which read unsigned is exactly
        // the required magnitude 2^(WIDTH-1).
        a_mag = (is_signed && ea[WIDTH-1]) ? (~ea + 1'b1) : ea;
        b_mag = (is_signed && eb[WIDTH-1]) ? (~eb + 1'b1) : eb;
    end

    always_comb begin
        // Shift-add: the extra sum bit is the carry-out, which shifts into
        // the top of the accumulator.
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + (acc_reg[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

        // Restoring division: the shifted remainder can exceed WIDTH bits
        // before the subtract, so it is carried at WIDTH+1 bits.
        rem_sh   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        trial    = rem_sh - {1'b0, b_reg};
        trial_ok = (rem_sh >= {1'b0, b_reg});
        div_next = trial_ok ? {trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1}
                            : {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        prod_fix = neg_lo_reg ? (~acc_reg + 1'b1) : acc_reg;
        quo_fix  = neg_lo_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
        rem_fix  = neg_hi_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1)
                              : acc_reg[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            state_reg  <= IDLE;
            div_reg    <= 1'b0;
            b_reg      <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
            ehi_reg    <= '0;
            elo_reg    <= '0;
            ebusy_reg  <= 1'b0;
            edone_reg  <= 1'b0;
            edivz_reg  <= 1'b0;
        end else begin
            edone_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (estart) begin
                        div_reg    <= is_div;
                        b_reg      <= b_mag;
                        acc_reg    <= {{WIDTH{1'b0}}, a_mag};
                        count_reg  <= '0;
                        neg_lo_reg <= is_signed & (ea[WIDTH-1] ^ eb[WIDTH-1]);
                        neg_hi_reg <= is_signed & is_div & ea[WIDTH-1];
                        if (is_div && (eb == '0)) begin
                            // Divide by zero skips the iteration entirely.
                            ehi_reg   <= ea;
                            elo_reg   <= '1;
                            edivz_reg <= 1'b1;
                            edone_reg <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            ebusy_reg <= 1'b1;
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_reg   <= div_reg ? div_next : mul_next;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(WIDTH - 1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    if (div_reg) begin
                        ehi_reg <= rem_fix;
                        elo_reg <= quo_fix;
                    end else begin
                        ehi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        elo_reg <= prod_fix[WIDTH-1:0];
                    end
                    edivz_reg <= 1'b0;
                    ebusy_reg <= 1'b0;
                    edone_reg <= 1'b1;
                    state_reg <= DONE;
                end
                default: begin
                    // DONE: estart is deliberately not looked at here.
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ehi    = ehi_reg;
    assign elo    = elo_reg;
    assign ebusy  = ebusy_reg;
    assign edone  = edone_reg;
    assign edivz  = edivz_reg;
    assign estall = ebusy_reg | (estart & (state_reg == IDLE));

endmodule

// File: tb/tb_pipe_muldiv.sv
// ---------------------------------------------------------------------------
// tb_pipe_muldiv -- self-checking bench for pipe_muldiv (WIDTH = 32).
// Directed cases plus randomized operations, each compared against a
// reference model that uses plain integer multiply / divide / remainder.
// ---------------------------------------------------------------------------
module tb_pipe_muldiv;

    localparam int W = 32;

    logic          clock;
    logic          clr;
    logic          estart;
    logic [1:0]    eop;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
    logic [W-1:0]  ehi;
    logic [W-1:0]  elo;
    logic          ebusy;
    logic          edone;
    logic          edivz;
    logic          estall;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural HI/LO/divz as the bench expects them to be right now.
    logic [W-1:0]  model_hi;
    logic [W-1:0]  model_lo;
    logic          model_dz;

    pipe_muldiv #(.WIDTH(W)) dut (
        .clock  (clock),
        .clr    (clr),
        .estart (estart),
        .eop    (eop),
        .ea     (ea),
        .eb     (eb),
        .ehi    (ehi),
        .elo    (elo),
        .ebusy  (ebusy),
        .edone  (edone),
        .edivz  (edivz),
        .estall (estall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: MIPS semantics written with ordinary integer arithmetic.
    task automatic ref_model(input logic [1:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, output logic [W-1:0] hi,
                             output logic [W-1:0] lo, output logic dz);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = 1'b0;
        case (op)
            2'b00: begin
                sq = sa * sb;
                hi = sq[63:32];
                lo = sq[31:0];
            end
            2'b01: begin
                up = ua * ub;
                hi = up[63:32];
                lo = up[31:0];
            end
            default: begin
                if (b == '0) begin
                    hi = a;
                    lo = '1;
                    dz = 1'b1;
                end else if (op == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    hi = sr[31:0];
                    lo = sq[31:0];
                end else begin
                    up = ua / ub;
                    hi = 32'(ua % ub);
                    lo = up[31:0];
                end
            end
        endcase
    endtask

    // Called at a negedge (start cycle 0). Returns at the negedge of the
    // cycle after DONE, with the unit idle.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit hold_start);
        logic [W-1:0] exp_hi, exp_lo;
        logic         exp_dz;
        int           lat;
        ref_model(op, a, b, exp_hi, exp_lo, exp_dz);
        lat = exp_dz ? 1 : W + 2;

        estart = 1'b1;
        eop    = op;
        ea     = a;
        eb     = b;
        #1;
        check_value("estall_c0", estall, 1);
        @(posedge clock);
        #1;
        estart = 1'b0;
        eop    = 2'($urandom);
        ea     = $urandom;
        eb     = $urandom;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge clock);
            check_value("estall", estall, (cyc < lat) ? 1 : 0);
            check_value("ebusy", ebusy, (cyc < lat) ? 1 : 0);
            check_value("edone", edone, (cyc == lat) ? 1 : 0);
            if (cyc < lat) begin
                check_value("hi_stable", ehi, model_hi);
                check_value("lo_stable", elo, model_lo);
                check_value("dz_stable", edivz, model_dz);
            end
        end
        check_value("ehi", ehi, exp_hi);
        check_value("elo", elo, exp_lo);
        check_value("edivz", edivz, exp_dz);
        $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dz=%0d (exp 0x%08h 0x%08h %0d) lat=%0d",
                 op, a, b, ehi, elo, edivz, exp_hi, exp_lo, exp_dz, lat);
        model_hi = exp_hi;
        model_lo = exp_lo;
        model_dz = exp_dz;
        if (hold_start) begin
            // A DIVU by zero offered during DONE must not be taken.
            estart = 1'b1;
            eop    = 2'b11;
            eb     = '0;
        end
        @(negedge clock);
        estart = 1'b0;
        #1;
        check_value("post_ebusy", ebusy, 0);
        check_value("post_edone", edone, 0);
        check_value("post_estall", estall, 0);
        check_value("post_hi", ehi, model_hi);
        check_value("post_dz", edivz, model_dz);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   rop;

        clr    = 1'b1;
        estart = 1'b0;
        eop    = 2'b00;
        ea     = '0;
        eb     = '0;
        model_hi = '0;
        model_lo = '0;
        model_dz = 1'b0;
        repeat (3) @(negedge clock);
        check_value("rst_ehi", ehi, 0);
        check_value("rst_elo", elo, 0);
        check_value("rst_ebusy", ebusy, 0);
        check_value("rst_edone", edone, 0);
        check_value("rst_edivz", edivz, 0);
        check_value("rst_estall", estall, 0);
        clr = 1'b0;
        @(negedge clock);

        // Directed cases
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b11, 32'd100, 32'd0, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 32'd7, 32'd0, 1'b1);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);

        // Load HI/LO = 5/6, then abort a DIVU with clr in cycle 10
        run_op(2'b11, 32'd47, 32'd7, 1'b0);
        estart = 1'b1;
        eop    = 2'b11;
        ea     = 32'd1000;
        eb     = 32'd3;
        @(posedge clock);
        #1;
        estart = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clock);
            check_value("abort_busy", ebusy, 1);
        end
        clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
        check_value("abort_ebusy", ebusy, 0);
        check_value("abort_ehi", ehi, 0);
        check_value("abort_elo", elo, 0);
        check_value("abort_estall", estall, 0);
        model_hi = '0;
        model_lo = '0;
        model_dz = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clock);
            check_value("abort_no_done", edone, 0);
            check_value("abort_hi_hold", ehi, 0);
        end

        // Back-to-back: second start lands in cycle 35 of the first op
        run_op(2'b01, 32'd6, 32'd7, 1'b0);
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0);

        // Randomized operations with a bias toward corner operands
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'($urandom_range(0, 20));
                2:       ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                3:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_muldiv.md
Name: pipe_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage of the pipelined CPU, one stage upstream of the memory stage.
- Executes MULT/MULTU/DIV/DIVU on the ID/EX operands and holds HI/LO for MFHI/MFLO.
- Freezes the front of the pipeline through estall until the result is ready, so the instruction then proceeds to EX/MEM and the memory stage.
- One radix-2 iteration per clock.

Parameters:
WIDTH, 32, operand width; ehi/elo are WIDTH bits, the internal product is 2*WIDTH bits.

Ports:
clock  in  1  pipeline clock (same clock as the EX/MEM register)
clr  in  1  reset; synchronous, active-high
estart  in  1  instruction in EX is a mul/div; sampled only in IDLE
eop  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
ea  in  WIDTH  rs operand, after forwarding
eb  in  WIDTH  rt operand, after forwarding
ehi  out  WIDTH  HI register (product upper half / remainder)
elo  out  WIDTH  LO register (product lower half / quotient)
ebusy  out  1  registered; high in RUN and FIX
edone  out  1  registered; one-cycle pulse in DONE
edivz  out  1  registered; divide-by-zero flag of the last completed op, held
estall  out  1  combinational: ebusy | (estart & state==IDLE)

Behaviour:

Reset (clr=1 at a rising edge):
- state=IDLE; ehi=elo=0; ebusy=edone=edivz=0; iteration count=0.
- Reset wins over every other event, including mid-RUN and mid-FIX.
- The aborted op leaves no partial HI/LO update.

States:
- IDLE:
  - estart=1 latches eop, |ea|, |eb| (absolute values for signed ops; raw values for unsigned) and the result sign bits; clears the accumulator and count.
  - Next state is RUN.
  - Exception: DIV/DIVU with eb==0 goes directly to DONE with ehi=ea, elo={WIDTH{1}}, edivz=1.
- RUN: exactly WIDTH cycles; count runs 0..WIDTH-1, then FIX.
  - Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand to the upper accumulator half; shift the 2*WIDTH accumulator right by 1, keeping the carry-out.
  - Divide: restoring. Shift {rem,quo} left by 1; trial-subtract the divisor from rem; if non-negative, keep the difference and set quo LSB=1.
- FIX, 1 cycle:
  - Apply signs. Product is negated if the operand signs differ (signed only).
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Write ehi/elo; edivz=0.
- DONE, 1 cycle: edone=1; estart is ignored; next state is IDLE.

Latency and handshake:
- Start accepted in cycle 0. RUN occupies cycles 1..WIDTH, FIX is cycle WIDTH+1, DONE is cycle WIDTH+2 (34 for WIDTH=32).
- estall is high in cycles 0..WIDTH+1 and low in DONE, so the owning instruction leaves EX in DONE.
- The next mul/div can start no earlier than the following cycle, in IDLE.
- ehi/elo are updated only at the end of FIX (or the divide-by-zero transition) and are stable otherwise.
- ea/eb/eop changes after cycle 0 have no effect.

Arithmetic corner cases:
- DIV 0x80000000 / 0xFFFFFFFF gives elo=0x80000000, ehi=0 (wraps, no trap).
- Divide by zero completes in 2 cycles (start, DONE); estall is high in cycle 0 only.
- Operand magnitude of -2^(WIDTH-1) is handled as the unsigned value 2^(WIDTH-1).

Test Plan:
- MULTU ea=0xFFFFFFFF eb=0xFFFFFFFF -> edone in cycle 34; ehi=0xFFFFFFFE, elo=0x00000001; estall high in cycles 0-33, low in 34.
- MULT ea=0xFFFFFFFD (-3) eb=7 -> ehi=0xFFFFFFFF, elo=0xFFFFFFEB; DIV ea=0xFFFFFFF9 (-7) eb=2 -> elo=0xFFFFFFFD, ehi=0xFFFFFFFF.
- DIVU ea=100 eb=0 -> edone in cycle 1; ehi=0x00000064, elo=0xFFFFFFFF, edivz=1; a subsequent DIVU 100/7 -> elo=14, ehi=2, edivz=0.
- DIV ea=0x80000000 eb=0xFFFFFFFF -> elo=0x80000000, ehi=0, edivz=0.
- Start DIVU 1000/3 (ehi/elo previously 5/6), assert clr in cycle 10 -> next cycle state IDLE, ebusy=0, ehi=elo=0, no edone pulse; estart held high during DONE is ignored.
- Back-to-back: MULTU 6*7 then MULTU 0x10000*0x10000 with estart re-asserted in cycle 35 -> first result elo=42, ehi=0; second edone in cycle 69 with ehi=1, elo=0.
